// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: register scoreboard, RAW stall, branch flush, HALT drain
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [2:0]  id_rs,
    input  logic [2:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_wr_en,
    input  logic [2:0]  id_wr_reg,
    input  logic        id_halt,
    input  logic        br_taken,
    input  logic        mem_stall,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        exmem_we,
    output logic        memwb_we,
    output logic        halted,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrlState;

    ctrlState   state;
    logic [1:0] busy [8];
    logic [1:0] drainCnt;

    logic freeze;
    logic running;
    logic rsHazard;
    logic rtHazard;
    logic raw;
    logic flush;
    logic issue;

    assign freeze   = mem_stall;
    assign running  = (state == RUN);
    // A counter of 1 means the writer is in WB; the register file bypasses that case.
    assign rsHazard = id_use_rs && (busy[id_rs] >= 2'd2);
    assign rtHazard = id_use_rt && (busy[id_rt] >= 2'd2);
    assign raw      = id_valid && (rsHazard || rtHazard);
    assign flush    = br_taken && !freeze && running;
    assign issue    = id_valid && !raw && !flush && !freeze && running;
    assign halted   = (state == HALTED);

    always_comb begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_we    = 1'b0;
        memwb_we    = 1'b0;
        if (!freeze) begin
            exmem_we = 1'b1;
            memwb_we = 1'b1;
            if (!running) begin
                idex_bubble = 1'b1;
            end else if (flush) begin
                pc_we       = 1'b1;
                ifid_we     = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (raw) begin
                idex_bubble = 1'b1;
            end else begin
                pc_we   = 1'b1;
                ifid_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                busy[i] <= 2'd0;
            end
            drainCnt    <= 2'd0;
            state       <= RUN;
            stall_count <= 16'd0;
        end else if (!freeze) begin
            for (int i = 0; i < 8; i++) begin
                if (busy[i] != 2'd0) begin
                    busy[i] <= busy[i] - 2'd1;
                end
            end
            // Later assignment wins, so a fresh writer overrides the decrement.
            if (issue && id_wr_en) begin
                busy[id_wr_reg] <= 2'd3;
            end
            if (running && raw && !flush && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
            case (state)
                RUN: begin
                    if (issue && id_halt) begin
                        state    <= DRAIN;
                        drainCnt <= 2'd3;
                    end
                end
                DRAIN: begin
                    drainCnt <= drainCnt - 2'd1;
                    if (drainCnt == 2'd1) begin
                        state <= HALTED;
                    end
                end
                HALTED: state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - table-driven bench for hazard_ctrl
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [2:0]  id_rs;
    logic [2:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_wr_en;
    logic [2:0]  id_wr_reg;
    logic        id_halt;
    logic        br_taken;
    logic        mem_stall;
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        exmem_we;
    logic        memwb_we;
    logic        halted;
    logic [15:0] stall_count;

    int errors = 0;
    int checks = 0;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
        .id_wr_reg(id_wr_reg), .id_halt(id_halt), .br_taken(br_taken),
        .mem_stall(mem_stall), .pc_we(pc_we), .ifid_we(ifid_we),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_we(exmem_we),
        .memwb_we(memwb_we), .halted(halted), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Expected enable modes, packed as {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we}
    localparam logic [5:0] MN = 6'b110011;
    localparam logic [5:0] MS = 6'b000111;
    localparam logic [5:0] MF = 6'b111111;
    localparam logic [5:0] MZ = 6'b000000;

    typedef struct {
        logic        rst;
        logic        ms;
        logic        br;
        logic        valid;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic        useRs;
        logic        useRt;
        logic        wrEn;
        logic [2:0]  wrReg;
        logic        halt;
        logic [5:0]  expEn;
        logic        expHalted;
        logic [15:0] expCount;
    } vecT;

    vecT vecs[$];

    task automatic addVec(input logic rst, input logic ms, input logic br, input logic v,
                          input logic [2:0] rs, input logic [2:0] rt, input logic urs,
                          input logic urt, input logic we, input logic [2:0] wr, input logic h,
                          input logic [5:0] en, input logic hl, input logic [15:0] sc);
        vecT t;
        t.rst = rst; t.ms = ms; t.br = br; t.valid = v; t.rs = rs; t.rt = rt;
        t.useRs = urs; t.useRt = urt; t.wrEn = we; t.wrReg = wr; t.halt = h;
        t.expEn = en; t.expHalted = hl; t.expCount = sc;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vecT t);
        rst_n = t.rst; mem_stall = t.ms; br_taken = t.br; id_valid = t.valid;
        id_rs = t.rs; id_rt = t.rt; id_use_rs = t.useRs; id_use_rt = t.useRt;
        id_wr_en = t.wrEn; id_wr_reg = t.wrReg; id_halt = t.halt;
    endtask

    initial begin
        vecT idle;
        idle = '{rst: 1'b0, ms: 1'b0, br: 1'b0, valid: 1'b0, rs: 3'd0, rt: 3'd0,
                 useRs: 1'b0, useRt: 1'b0, wrEn: 1'b0, wrReg: 3'd0, halt: 1'b0,
                 expEn: MN, expHalted: 1'b0, expCount: 16'd0};

        //     rst ms br v  rs rt urs urt we wr h   en  hl sc
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MN, 0, 0);
        // back-to-back RAW on R3
        addVec(1, 0, 0, 1, 1, 0, 1, 0, 1, 3, 0, MN, 0, 0);
        addVec(1, 0, 0, 1, 3, 0, 1, 0, 0, 0, 0, MS, 0, 0);
        addVec(1, 0, 0, 1, 3, 0, 1, 0, 0, 0, 0, MS, 0, 1);
        addVec(1, 0, 0, 1, 3, 0, 1, 0, 0, 0, 0, MN, 0, 2);
        // distance-3 dependency on R5
        addVec(1, 0, 0, 1, 0, 0, 0, 0, 1, 5, 0, MN, 0, 2);
        addVec(1, 0, 0, 1, 1, 2, 1, 1, 0, 0, 0, MN, 0, 2);
        addVec(1, 0, 0, 1, 1, 2, 1, 1, 0, 0, 0, MN, 0, 2);
        addVec(1, 0, 0, 1, 0, 5, 0, 1, 0, 0, 0, MN, 0, 2);
        // branch beats RAW; killed writer of R7 leaves R7 free
        addVec(1, 0, 0, 1, 0, 0, 0, 0, 1, 4, 0, MN, 0, 2);
        addVec(1, 0, 1, 1, 4, 0, 1, 0, 1, 7, 0, MF, 0, 2);
        addVec(1, 0, 0, 1, 7, 0, 1, 0, 0, 0, 0, MN, 0, 2);
        // mem_stall freezes busy[2]=3 for 4 cycles
        addVec(1, 0, 0, 1, 0, 0, 0, 0, 1, 2, 0, MN, 0, 2);
        addVec(1, 1, 0, 1, 2, 0, 1, 0, 0, 0, 0, MZ, 0, 2);
        addVec(1, 1, 0, 1, 2, 0, 1, 0, 0, 0, 0, MZ, 0, 2);
        addVec(1, 1, 1, 1, 2, 0, 1, 0, 0, 0, 0, MZ, 0, 2);
        addVec(1, 1, 1, 1, 2, 0, 1, 0, 0, 0, 0, MZ, 0, 2);
        addVec(1, 0, 0, 1, 2, 0, 1, 0, 0, 0, 0, MS, 0, 2);
        addVec(1, 0, 0, 1, 2, 0, 1, 0, 0, 0, 0, MS, 0, 3);
        addVec(1, 0, 0, 1, 2, 0, 1, 0, 0, 0, 0, MN, 0, 4);
        // br_taken held through mem_stall flushes on release
        addVec(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, MZ, 0, 4);
        addVec(1, 0, 1, 1, 0, 0, 0, 0, 1, 6, 0, MF, 0, 4);
        addVec(1, 0, 0, 1, 6, 0, 1, 0, 0, 0, 0, MN, 0, 4);
        // HALT drain, RAW in DRAIN not counted, br ignored, reset beats mem_stall
        addVec(1, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1, MN, 0, 4);
        addVec(1, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, MS, 0, 4);
        addVec(1, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0, MZ, 0, 4);
        addVec(1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, MS, 0, 4);
        addVec(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, MS, 0, 4);
        addVec(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, MS, 1, 4);
        addVec(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, MZ, 1, 4);
        addVec(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, MZ, 1, 4);
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MN, 0, 0);

        drive(idle);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #2;
            check($sformatf("enables[%0d]", i),
                  {10'd0, pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we},
                  {10'd0, vecs[i].expEn});
            check($sformatf("halted[%0d]", i), {15'd0, halted}, {15'd0, vecs[i].expHalted});
            check($sformatf("stall_count[%0d]", i), stall_count, vecs[i].expCount);
            @(posedge clk);
            #1;
        end

        // Saturation: a self-dependent writer of R1 stalls 2 of every 3 cycles.
        drive(idle);
        @(posedge clk);
        #1;
        rst_n = 1'b1; id_valid = 1'b1; id_rs = 3'd1; id_use_rs = 1'b1;
        id_wr_en = 1'b1; id_wr_reg = 3'd1;
        repeat (3000) @(posedge clk);
        #1;
        check("stall_count_mid", stall_count, 16'd2000);
        repeat (95310) @(posedge clk);
        #1;
        check("stall_count_sat", stall_count, 16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        check("stall_count_hold", stall_count, 16'hFFFF);
        check("sat_stall_pc_we", {15'd0, pc_we}, 16'd1);
        @(posedge clk);
        #1;
        check("sat_stall_bubble", {15'd0, idex_bubble}, 16'd1);
        check("stall_count_hold2", stall_count, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
